// File: rtl/result_uart_tx_pkg.sv
// Shared types and helpers for the result UART transmitter (and a future receiver).
package result_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } txState_t;

    // Upper bits of an error frame; the low three bits carry the FIFO error flags.
    localparam logic [6:0] ERR_PREFIX = 7'b1111111;

    function automatic logic evenParity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/result_uart_tx_if.sv
// Sequencer-to-transmitter handshake: word/error in, serial line and status out.
interface result_uart_tx_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] result_tr;
    logic [2:0]        error_reg;
    logic              send;
    logic              t;
    logic              ready_next;
    logic              busy;

    modport master (
        output result_tr, error_reg, send,
        input  t, ready_next, busy
    );

    modport slave (
        input  result_tr, error_reg, send,
        output t, ready_next, busy
    );
endinterface

// File: rtl/result_uart_tx_baud_tick_gen.sv
// Baud divider: one-cycle tick on the last clock of every CLKS_PER_BIT-cycle bit period.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);
    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    // Held at zero while disabled so every frame starts on a full bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || !i_enable || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = i_enable && (r_count == LAST);
endmodule

// File: rtl/result_uart_tx.sv
// Frames a result word or error code as start/data(LSB first)/parity/stop and shifts it out on t.
import result_uart_pkg::*;

module result_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 10,
    parameter int PARITY_EN    = 1
) (
    input logic             clk,
    input logic             rst_n,
    result_uart_tx_if.slave bus
);
    localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    txState_t          r_state, w_stateNext;
    logic [DATA_W-1:0] r_shift, w_shiftNext, w_word;
    logic [BIT_W-1:0]  r_bitCnt, w_bitCntNext;
    logic              r_parity, w_parityNext;
    logic              r_t, w_tNext;
    logic              r_readyNext, w_readyNextNext;
    logic              r_busy, w_busyNext;
    logic              w_accept, w_tick, w_frameActive;

    assign w_word = (bus.error_reg != 3'b000) ? DATA_W'({ERR_PREFIX, bus.error_reg})
                                              : bus.result_tr;
    assign w_frameActive = (r_state != IDLE);

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (w_frameActive),
        .i_clear  (w_accept),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_stateNext     = r_state;
        w_shiftNext     = r_shift;
        w_bitCntNext    = r_bitCnt;
        w_parityNext    = r_parity;
        w_tNext         = r_t;
        w_readyNextNext = 1'b0;
        w_busyNext      = r_busy;
        w_accept        = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_tNext = 1'b1;
                if (bus.send) begin
                    w_accept     = 1'b1;
                    w_stateNext  = START;
                    w_shiftNext  = w_word;
                    w_bitCntNext = '0;
                    w_parityNext = (PARITY_EN != 0) ? evenParity(32'(w_word)) : 1'b0;
                    w_tNext      = 1'b0;
                    w_busyNext   = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    w_stateNext = DATA;
                    w_tNext     = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bitCnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            w_stateNext = PARITY;
                            w_tNext     = r_parity;
                        end else begin
                            w_stateNext = STOP;
                            w_tNext     = 1'b1;
                        end
                    end else begin
                        w_shiftNext  = r_shift >> 1;
                        w_tNext      = w_shiftNext[0];
                        w_bitCntNext = r_bitCnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_stateNext = STOP;
                    w_tNext     = 1'b1;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_stateNext     = IDLE;
                    w_tNext         = 1'b1;
                    w_busyNext      = 1'b0;
                    w_readyNextNext = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_tNext     = 1'b1;
                w_busyNext  = 1'b0;
            end
        endcase
    end

    // Line and status are registered so t never glitches and falls exactly on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_parity    <= 1'b0;
            r_t         <= 1'b1;
            r_readyNext <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_shift     <= w_shiftNext;
            r_bitCnt    <= w_bitCntNext;
            r_parity    <= w_parityNext;
            r_t         <= w_tNext;
            r_readyNext <= w_readyNextNext;
            r_busy      <= w_busyNext;
        end
    end

    assign bus.t          = r_t;
    assign bus.ready_next = r_readyNext;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench: stimulus queues expected frames, a negedge monitor checks every line cycle.
module tb_result_uart_tx;
    localparam int CPB          = 4;
    localparam int DATA_W       = 10;
    localparam int FRAME_BITS   = DATA_W + 3;
    localparam int FRAME_CYCLES = FRAME_BITS * CPB;

    logic clk;
    logic rst_n;

    result_uart_tx_if #(.DATA_W(DATA_W)) bus ();

    result_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DATA_W),
        .PARITY_EN    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [FRAME_BITS-1:0] expQ[$];
    logic [FRAME_BITS-1:0] curFrame;
    int testCount  = 0;
    int failCount  = 0;
    int framesDone = 0;
    int cyc        = 0;
    bit inFrame    = 1'b0;
    int target     = 0;

    // Reference frame: start 0, word LSB first, even parity from a ones count, stop 1.
    function automatic logic [FRAME_BITS-1:0] buildFrame(input logic [9:0] w, input logic [2:0] e);
        logic [9:0] word;
        int         ones;
        logic       par;
        word = (e != 3'd0) ? {7'b1111111, e} : w;
        ones = 0;
        for (int i = 0; i < 10; i++) ones += int'(word[i]);
        par = ((ones % 2) == 1) ? 1'b1 : 1'b0;
        return {1'b1, par, word, 1'b0};
    endfunction

    task automatic checkOutput(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s cycle %0d: got t/busy/ready=%b required %b", name, idx, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            inFrame = 1'b0;
            checkOutput("reset", cyc, {bus.t, bus.busy, bus.ready_next}, 3'b100);
        end else begin
            if (!inFrame && (bus.t === 1'b0)) begin
                if (expQ.size() == 0) begin
                    curFrame = '1;
                    testCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_frame: got t=0 required idle line");
                end else begin
                    curFrame = expQ.pop_front();
                end
                inFrame = 1'b1;
                cyc     = 0;
            end
            if (inFrame) begin
                if (cyc < FRAME_CYCLES) begin
                    checkOutput("frame_bit", cyc, {bus.t, bus.busy, bus.ready_next},
                                {curFrame[cyc / CPB], 1'b1, 1'b0});
                end else begin
                    checkOutput("frame_end", cyc, {bus.t, bus.busy, bus.ready_next}, 3'b101);
                    inFrame = 1'b0;
                    framesDone++;
                end
                cyc++;
            end else begin
                checkOutput("idle", 0, {bus.t, bus.busy, bus.ready_next}, 3'b100);
            end
        end
    end

    task automatic applyStimulus(input logic [9:0] w, input logic [2:0] e, input bit expectAccept);
        @(posedge clk);
        #1;
        bus.result_tr = w;
        bus.error_reg = e;
        bus.send      = 1'b1;
        if (expectAccept) expQ.push_back(buildFrame(w, e));
        @(posedge clk);
        #1;
        bus.send      = 1'b0;
        bus.result_tr = 10'($urandom);
        bus.error_reg = 3'($urandom);
    endtask

    task automatic waitFrames(input int n);
        for (int i = 0; i < 400; i++) begin
            if (framesDone >= n) return;
            @(posedge clk);
        end
        $display("[TB] FAIL frame_timeout: got %0d frames required %0d", framesDone, n);
        $fatal(1, "[TB] frame timeout");
    endtask

    // Wait for the ready_next cycle, then issue send inside it for a back-to-back frame.
    task automatic sendInReadyCycle(input logic [9:0] w, input logic [2:0] e);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_next) seen = 1'b1;
        end
        if (!seen) begin
            $display("[TB] FAIL ready_timeout: got no ready_next required one");
            $fatal(1, "[TB] ready timeout");
        end
        bus.result_tr = w;
        bus.error_reg = e;
        bus.send      = 1'b1;
        expQ.push_back(buildFrame(w, e));
        @(posedge clk);
        #1;
        bus.send = 1'b0;
    endtask

    initial begin
        logic [9:0] rw;
        logic [2:0] re;
        rst_n         = 1'b0;
        bus.send      = 1'b0;
        bus.result_tr = '0;
        bus.error_reg = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);

        applyStimulus(10'h2A5, 3'b000, 1'b1);
        waitFrames(++target);

        applyStimulus(10'h155, 3'b010, 1'b1);
        waitFrames(++target);

        applyStimulus(10'h2A5, 3'b000, 1'b1);
        repeat (9) @(posedge clk);
        applyStimulus(10'h0F0, 3'b000, 1'b0);
        waitFrames(++target);
        repeat (5) @(posedge clk);

        applyStimulus(10'h2A5, 3'b000, 1'b1);
        sendInReadyCycle(10'h001, 3'b000);
        target += 2;
        waitFrames(target);

        applyStimulus(10'h3C7, 3'b000, 1'b1);
        repeat (21) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        applyStimulus(10'h000, 3'b000, 1'b1);
        waitFrames(++target);

        for (int k = 0; k < 8; k++) begin
            rw = 10'($urandom_range(0, 1023));
            re = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            applyStimulus(rw, re, 1'b1);
            waitFrames(++target);
        end

        rw = 10'($urandom_range(0, 1023));
        applyStimulus(rw, 3'b000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            rw = 10'($urandom_range(0, 1023));
            re = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            sendInReadyCycle(rw, re);
        end
        target += 4;
        waitFrames(target);
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Serial output stage directly downstream of the top-level result sequencer.
- Accepts one 10-bit result word, or an error code, per `send` pulse.
- Frames it as start bit, LSB-first data, even parity and stop bit, and shifts it out on line `t`.
- Pulses `ready_next` when the line is free, so the sequencer can advance to the next word.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (baud divider); legal range ≥ 2.
- DATA_W, 10, width of the result word.
- PARITY_EN, 1, 1 = append even-parity bit; 0 = omit it.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- result_tr  input  DATA_W  result word to send; sampled on accepted `send`.
- error_reg  input  3  error flags from FIFO; nonzero on accepted `send` selects error frame.
- send  input  1  request; one-cycle pulse, sampled only in IDLE.
- t  output  1  serial line; idle high.
- ready_next  output  1  one-cycle pulse: frame finished, line idle.
- busy  output  1  high from acceptance until the frame ends.

Behaviour:
Reset:
- Asynchronous on rst_n=0: t=1, ready_next=0, busy=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame aborts the frame immediately; no ready_next is produced.

Acceptance (IDLE with send=1 on a rising edge):
- Latch word W = (error_reg != 0) ? {7'b1111111, error_reg} : result_tr.
- Compute parity P = ^W (even parity).
- Enter START; set busy=1.
- t falls to 0 on that same edge, i.e. visible one cycle after send is sampled.

State machine (each bit held exactly CLKS_PER_BIT cycles by the baud counter):
- IDLE -> START: on send.
- START (t=0) -> DATA.
- DATA: shifts t = W[k] for k = 0..DATA_W-1, LSB first; bit counter 0..DATA_W-1. After the last bit -> PARITY if PARITY_EN, else STOP.
- PARITY (t=P) -> STOP.
- STOP (t=1) -> IDLE at the end of its bit period. On that edge: busy=0 and ready_next=1 for exactly one cycle.

Timing:
- Frame length = (DATA_W + 2 + PARITY_EN) × CLKS_PER_BIT cycles, measured from the t falling edge to the ready_next rising edge.
- Default: 13 × CLKS_PER_BIT.

Boundary conditions:
- send while busy: ignored; no queueing, no effect on the current frame.
- send in the ready_next cycle (state already IDLE): accepted; the new frame starts next edge, giving back-to-back frames with no extra idle bit beyond the stop bit.
- result_tr and error_reg may change after acceptance; the latched W is used.
- Baud counter width = $clog2(CLKS_PER_BIT); it wraps to 0 at CLKS_PER_BIT-1.
- Bit counter width = $clog2(DATA_W).
- No X on t in any state.

Decomposition:
- Package result_uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - ERR_PREFIX = 7'b1111111;
  - function for parity.
- Sub-module baud_tick_gen (counter that emits a one-cycle `tick` every CLKS_PER_BIT cycles, cleared on frame start). It is natural and reusable by the receiver.
- Remaining shifter/FSM stays in result_uart_tx.

Test Plan (CLKS_PER_BIT=4, DATA_W=10, PARITY_EN=1):
1. Reset, then idle 20 cycles -> t=1, busy=0, ready_next=0 throughout.
2. send pulse, result_tr=10'h2A5, error_reg=0 -> t sequence, each bit 4 cycles: 0,1,0,1,0,0,1,0,1,0,1,1(parity),1(stop). ready_next pulses once, 52 cycles after t falls.
3. send with error_reg=3'b010, result_tr=10'h155 -> W=10'h3FA; data bits 0,1,0,1,1,1,1,1,1,1; parity 0; stop 1; ready_next once.
4. Second send pulse at frame cycle 10 of scenario 2 -> ignored: frame unchanged, exactly one ready_next.
5. send asserted in the ready_next cycle with result_tr=10'h001 -> t falls on the next edge. Second frame data bits 1,0,0,0,0,0,0,0,0,0, parity 1.
6. rst_n low during DATA bit 4 -> t=1 and busy=0 asynchronously, with no ready_next. After release, a new send with 10'h000 gives a correct frame, parity 0.
